// File: rtl/set_scan_ctrl.sv
// Scan controller for the circle-coverage engine: latches three circles and a set mode,
// sweeps the 8x8 grid through one combinational PE and counts points that satisfy the mode.
module set_scan_ctrl #(
  parameter int GRID_MAX = 8,
  parameter int COORD_W  = 4,
  parameter int CNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en_i,
  input  logic [6*COORD_W-1:0] central_i,
  input  logic [3*COORD_W-1:0] radius_i,
  input  logic [1:0]           mode_i,
  output logic                 busy_o,
  output logic                 valid_o,
  output logic [CNT_W-1:0]     candidate_o,
  output logic [2*COORD_W-1:0] coord_o,
  output logic [6*COORD_W-1:0] cent_buf_o,
  output logic [3*COORD_W-1:0] r_buf_o,
  input  logic [2:0]           covered_i,
  output logic [1:0]           dbg_state_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [COORD_W-1:0] G_MAX = COORD_W'(GRID_MAX);
  localparam logic [COORD_W-1:0] G_ONE = COORD_W'(1);

  logic [1:0]           state_q, state_d;
  logic [6*COORD_W-1:0] cent_q, cent_d;
  logic [3*COORD_W-1:0] rad_q, rad_d;
  logic [1:0]           mode_q, mode_d;
  logic [COORD_W-1:0]   x_q, x_d, y_q, y_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [CNT_W-1:0]     cand_q, cand_d;
  logic                 busy_q, busy_d;
  logic                 valid_q, valid_d;

  logic                 a, b, c, pred, last_pt;
  logic [CNT_W-1:0]     count_inc;

  assign a = covered_i[2];
  assign b = covered_i[1];
  assign c = covered_i[0];

  always_comb begin
    pred = 1'b0;
    case (mode_q)
      2'd0:    pred = a;
      2'd1:    pred = a & b;
      2'd2:    pred = a ^ b;
      default: pred = (a & b & ~c) | (a & ~b & c) | (~a & b & c);
    endcase
  end

  assign last_pt   = (x_q == G_MAX) && (y_q == G_MAX);
  assign count_inc = count_q + CNT_W'(pred);

  // Handshake: busy_o is high from the first SCAN cycle through the DONE cycle; valid_o
  // pulses for the single DONE cycle, when candidate_o first shows the new count.
  always_comb begin
    state_d = state_q;
    cent_d  = cent_q;
    rad_d   = rad_q;
    mode_d  = mode_q;
    x_d     = x_q;
    y_d     = y_q;
    count_d = count_q;
    cand_d  = cand_q;
    busy_d  = busy_q;
    valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (en_i) begin
          cent_d  = central_i;
          rad_d   = radius_i;
          mode_d  = mode_i;
          x_d     = G_ONE;
          y_d     = G_ONE;
          count_d = '0;
          busy_d  = 1'b1;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        count_d = count_inc;
        if (last_pt) begin
          // Coordinate parks at the last point so the PE never sees an off-grid value.
          cand_d  = count_inc;
          valid_d = 1'b1;
          state_d = ST_DONE;
        end else if (x_q < G_MAX) begin
          x_d = x_q + G_ONE;
        end else begin
          x_d = G_ONE;
          y_d = y_q + G_ONE;
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cent_q  <= '0;
      rad_q   <= '0;
      mode_q  <= '0;
      x_q     <= G_ONE;
      y_q     <= G_ONE;
      count_q <= '0;
      cand_q  <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cent_q  <= cent_d;
      rad_q   <= rad_d;
      mode_q  <= mode_d;
      x_q     <= x_d;
      y_q     <= y_d;
      count_q <= count_d;
      cand_q  <= cand_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  assign busy_o      = busy_q;
  assign valid_o     = valid_q;
  assign candidate_o = cand_q;
  assign coord_o     = {x_q, y_q};
  assign cent_buf_o  = cent_q;
  assign r_buf_o     = rad_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_set_scan_ctrl.sv
// Bench for set_scan_ctrl: models the PE, runs directed and random jobs and compares
// each count with a grid-walk reference computed from the job's own circles.
module tb_set_scan_ctrl;

  logic        clk;
  logic        rst_n;
  logic        en_i;
  logic [23:0] central_i;
  logic [11:0] radius_i;
  logic [1:0]  mode_i;
  logic        busy_o;
  logic        valid_o;
  logic [7:0]  candidate_o;
  logic [7:0]  coord_o;
  logic [23:0] cent_buf_o;
  logic [11:0] r_buf_o;
  logic [2:0]  covered_i;
  logic [1:0]  dbg_state_o;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_cand = 8'h00;

  set_scan_ctrl dut (
    .clk(clk), .rst_n(rst_n), .en_i(en_i), .central_i(central_i),
    .radius_i(radius_i), .mode_i(mode_i), .busy_o(busy_o), .valid_o(valid_o),
    .candidate_o(candidate_o), .coord_o(coord_o), .cent_buf_o(cent_buf_o),
    .r_buf_o(r_buf_o), .covered_i(covered_i), .dbg_state_o(dbg_state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // coverage of point (x,y) by circles A,B,C: bit 2=A, 1=B, 0=C
  function automatic logic [2:0] cov_of(input logic [23:0] c, input logic [11:0] r,
                                        input int x, input int y);
    logic [2:0] res;
    int cx, cy, rr, dx, dy;
    res = 3'b000;
    for (int i = 0; i < 3; i++) begin
      cx = int'(c[23-8*i -: 4]);
      cy = int'(c[19-8*i -: 4]);
      rr = int'(r[11-4*i -: 4]);
      dx = x - cx;
      dy = y - cy;
      res[2-i] = (dx*dx + dy*dy) <= rr*rr;
    end
    return res;
  endfunction

  // PE stand-in driven from the DUT's latched buffers
  always_comb covered_i = cov_of(cent_buf_o, r_buf_o, int'(coord_o[7:4]), int'(coord_o[3:0]));

  function automatic logic [7:0] model_count(input logic [23:0] c, input logic [11:0] r,
                                             input logic [1:0] m);
    int n;
    logic [2:0] v;
    int ones;
    bit p;
    n = 0;
    for (int y = 1; y <= 8; y++)
      for (int x = 1; x <= 8; x++) begin
        v = cov_of(c, r, x, y);
        ones = int'(v[2]) + int'(v[1]) + int'(v[0]);
        case (m)
          2'd0: p = v[2];
          2'd1: p = v[2] && v[1];
          2'd2: p = v[2] != v[1];
          default: p = (ones == 2);
        endcase
        if (p) n++;
      end
    return 8'(n);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] cent(input int ax, ay, bx, by, cx, cy);
    return {4'(ax), 4'(ay), 4'(bx), 4'(by), 4'(cx), 4'(cy)};
  endfunction

  // one full job; starts in the next IDLE cycle, returns at the valid_o cycle
  task automatic run_job(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m,
                         input bit scramble);
    int k;
    bit busy_ok, coord_ok, seen;
    logic [7:0] exp_coord, exp_v;
    @(negedge clk);
    chk("idle_busy", 32'(busy_o), 32'd0);
    chk("idle_valid", 32'(valid_o), 32'd0);
    chk("cand_hold", 32'(candidate_o), 32'(last_cand));
    central_i = c;
    radius_i  = r;
    mode_i    = m;
    en_i      = 1'b1;
    exp_q.push_back(model_count(c, r, m));
    k = 0; busy_ok = 1; coord_ok = 1; seen = 0;
    while (k < 200 && !seen) begin
      @(negedge clk);
      k++;
      if (scramble) begin
        central_i = $urandom;
        radius_i  = 12'($urandom);
        mode_i    = 2'($urandom);
      end else begin
        en_i = 1'b0;
      end
      if (busy_o !== 1'b1) busy_ok = 0;
      if (valid_o === 1'b1) begin
        seen = 1;
      end else begin
        exp_coord = {4'((k-1) % 8 + 1), 4'((k-1) / 8 + 1)};
        if (k > 64 || coord_o !== exp_coord) coord_ok = 0;
        if (k == 1) chk("first_coord", 32'(coord_o), 32'h11);
      end
    end
    chk("valid_cycle", 32'(k), 32'd65);
    chk("busy_span", 32'(busy_ok), 32'd1);
    chk("coord_seq", 32'(coord_ok), 32'd1);
    chk("cent_latched", 32'(cent_buf_o), 32'(c));
    chk("rad_latched", 32'(r_buf_o), 32'(r));
    exp_v = exp_q.pop_front();
    chk("candidate", 32'(candidate_o), 32'(exp_v));
    last_cand = exp_v;
  endtask

  task automatic run_aborted(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m);
    bit no_valid;
    @(negedge clk);
    central_i = c; radius_i = r; mode_i = m; en_i = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      en_i = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_cand", 32'(candidate_o), 32'd0);
    chk("rst_coord", 32'(coord_o), 32'h11);
    chk("rst_cent", 32'(cent_buf_o), 32'd0);
    chk("rst_rad", 32'(r_buf_o), 32'd0);
    last_cand = 8'h00;
    no_valid = 1;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (valid_o !== 1'b0 || busy_o !== 1'b0) no_valid = 0;
    end
    chk("abort_silent", 32'(no_valid), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; en_i = 1'b0; central_i = '0; radius_i = '0; mode_i = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(busy_o), 32'd0);
    chk("reset_valid", 32'(valid_o), 32'd0);
    chk("reset_cand", 32'(candidate_o), 32'd0);
    chk("reset_coord", 32'(coord_o), 32'h11);
    rst_n = 1'b1;
    @(negedge clk);

    // directed cases with hand-derived counts
    run_job(cent(4,4, 7,2, 1,8), {4'd2, 4'd3, 4'd5}, 2'd0, 0);
    chk("plan_mode0", 32'(candidate_o), 32'd13);
    run_job(cent(3,3, 4,3, 8,8), {4'd1, 4'd1, 4'd0}, 2'd1, 0);
    chk("plan_mode1", 32'(candidate_o), 32'd2);
    run_job(cent(3,3, 4,3, 8,8), {4'd1, 4'd1, 4'd0}, 2'd2, 0);
    chk("plan_mode2", 32'(candidate_o), 32'd6);
    run_job(cent(4,4, 4,4, 4,4), {4'd2, 4'd2, 4'd2}, 2'd3, 0);
    chk("plan_mode3", 32'(candidate_o), 32'd0);
    run_job(cent(1,1, 2,2, 3,3), {4'd15, 4'd0, 4'd0}, 2'd0, 0);
    chk("plan_full", 32'(candidate_o), 32'h40);

    // en_i held with inputs churning, then a job starting in the first IDLE cycle
    run_job(cent(5,5, 6,5, 5,6), {4'd3, 4'd2, 4'd2}, 2'd3, 1);
    run_job(cent(2,7, 3,6, 8,1), {4'd4, 4'd3, 4'd6}, 2'd2, 0);

    run_aborted(cent(4,4, 2,2, 6,6), {4'd3, 4'd3, 4'd3}, 2'd0);
    run_job(cent(4,4, 2,2, 6,6), {4'd3, 4'd3, 4'd3}, 2'd0, 0);

    for (int j = 0; j < 5; j++)
      run_job($urandom, 12'($urandom), 2'($urandom_range(0, 3)), 0);

    en_i = 1'b0;
    @(negedge clk);
    chk("end_idle", 32'(busy_o), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/set_scan_ctrl.md
# set_scan_ctrl

Scan controller for the circle-coverage engine: the producer and consumer on the other side of the PE's combinational interface. It accepts three circles and a set-mode from the host. It then walks every point of the 8×8 grid (coordinates 1..8) through one PE, one point per cycle. It evaluates the selected set expression on the PE's coverage bits, counts qualifying points, and returns the count through a busy/valid handshake.

## Interface
- GRID_MAX, 8: highest grid coordinate. The scan covers 1..GRID_MAX on both axes.
- COORD_W, 4: width of one coordinate or radius field.
- CNT_W, 8: width of the candidate count.
- clk  input  1  rising-edge clock. This is the block's only clock.
- rst_n  input  1  reset. Synchronous and active-low.
- en_i  input  1  start request. Sampled only in IDLE.
- central_i  input  24  circle centres.
  - A_X [23:20], A_Y [19:16]
  - B_X [15:12], B_Y [11:8]
  - C_X [7:4], C_Y [3:0]
- radius_i  input  12  radii: A_R [11:8], B_R [7:4], C_R [3:0].
- mode_i  input  2  set expression selector.
- busy_o  output  1  high while a job is in progress.
- valid_o  output  1  one-cycle strobe; candidate_o is final.
- candidate_o  output  8  count of qualifying points.
- coord_o  output  8  point under test to the PE: X [7:4], Y [3:0].
- cent_buf_o  output  24  latched centres to the PE, same layout as central_i.
- r_buf_o  output  12  latched radii to the PE, same layout as radius_i.
- covered_i  input  3  coverage bits from the PE for coord_o, same cycle.
  - [2]=A, [1]=B, [0]=C.
  - 1 means the point is inside or on the circle (d² ≤ r²).

## Operation
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - busy_o=0, valid_o=0.
  - On en_i=1, latch central_i/radius_i/mode_i into cent_buf/r_buf/mode_buf.
  - Set coord X=1, Y=1, clear count to 0, go to SCAN.
- SCAN:
  - Each cycle, evaluate the predicate on covered_i. If true, count += 1.
  - Advance the point. If X<GRID_MAX, X+1. Otherwise X=1 and Y+1.
  - At (GRID_MAX,GRID_MAX), take the final count and go to DONE. The coordinate does not advance past (8,8).
- DONE:
  - candidate_o = count, valid_o=1 for exactly this cycle.
  - Then go to IDLE.
- Predicates, with a=covered_i[2], b=covered_i[1], c=covered_i[0]:
  - mode 0: a
  - mode 1: a & b
  - mode 2: a ^ b
  - mode 3: exactly two of {a, b, c}
- Count is CNT_W bits and never wraps. The maximum value is 64 (0x40).
- en_i in SCAN or DONE is ignored. The latched inputs are not disturbed.
- Changes on central_i/radius_i/mode_i after the latch have no effect on the job in flight.
- candidate_o holds the last result until the next DONE.
- Reset (rst_n=0 at any clock edge, including mid-scan):
  - State goes to IDLE.
  - count, candidate_o, busy_o and valid_o go to 0.
  - coord_o goes to 8'h11. cent_buf_o and r_buf_o go to 0.
  - A job interrupted by reset produces no valid_o.

## Timing
- en_i sampled at edge 0. The first SCAN cycle (point (1,1)) follows edge 0.
- SCAN lasts exactly 64 cycles. valid_o is high in cycle 65 after edge 0.
- busy_o is high in every SCAN and DONE cycle, i.e. from the cycle after edge 0 through the valid_o cycle. It is low in the cycle after valid_o.
- A new en_i is accepted in the first IDLE cycle after DONE. Back-to-back jobs start every 66 cycles.
- All outputs are registered. The PE path (coord_o to covered_i) is combinational within one cycle, so the accumulate happens on the same edge.

## Test plan
- Mode 0, A=(4,4) r=2, B and C arbitrary, en_i pulse -> busy 64+1 cycles, valid_o one cycle at cycle 65, candidate_o=13.
- Mode 1, A=(3,3) r=1, B=(4,3) r=1 -> candidate_o=2. Rerun with mode 2 -> candidate_o=6.
- Mode 3, A=B=C=(4,4) r=2 -> candidate_o=0. Then mode 0 with A=(1,1) r=15 -> candidate_o=64 (0x40), no wrap.
- Back-to-back:
  - Hold en_i=1 during the whole job with changing central_i -> the result matches the first latched values.
  - The second job starts in the first IDLE cycle after DONE.
- Drive rst_n=0 for one cycle at SCAN cycle 30 -> next cycle all outputs at reset values and no valid_o. A fresh en_i then yields the correct count.
- Coordinate sweep check: record coord_o during SCAN -> the sequence is 8'h11, 8'h21, …, 8'h81, 8'h12, …, 8'h88, with 64 distinct values.
